tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4.sv | 127 ++++++++++++
 tb/tb_tdm_demux4.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// tdm_demux4: de-serializes a 4-slot TDM word stream into parallel frames.
// HUNT waits for a start-of-frame word. LOCK stages slots 0..2 and publishes a
// whole frame when slot 3 arrives. Framing violations pulse sync_err.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sof,
    output logic [4*WIDTH-1:0] out_data,
    output logic               frame_valid,
    output logic               locked,
    output logic               sync_err,
    output logic [15:0]        frame_cnt,
    output logic [7:0]         err_cnt
);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t                    state, state_nxt;
    logic [1:0]                slot, slot_nxt;
    logic [1:0]                wr_idx;
    logic                      stage_wr;
    logic                      frame_done;
    logic                      err_det;
    // Slot 3 is never staged: it goes straight to out_data with slots 0..2.
    logic [2:0][WIDTH-1:0]     staging;

    assign locked = (state == LOCK);
    // A start-of-frame word always lands in slot 0, whatever the counter says.
    assign wr_idx = in_sof ? 2'd0 : slot;

    // State and slot-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            slot  <= 2'd0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
        end
    end

    // Next-state decode plus datapath strobes. Idle cycles change nothing.
    always_comb begin
        state_nxt  = state;
        slot_nxt   = slot;
        stage_wr   = 1'b0;
        frame_done = 1'b0;
        err_det    = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    // Words without sof are dropped silently while hunting.
                    if (in_sof) begin
                        stage_wr  = 1'b1;
                        slot_nxt  = 2'd1;
                        state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    if (in_sof) begin
                        // Early sof restarts the frame; an on-time sof is normal.
                        stage_wr = 1'b1;
                        slot_nxt = 2'd1;
                        err_det  = (slot != 2'd0);
                    end else if (slot == 2'd0) begin
                        // Missing sof where one was due: lose lock.
                        err_det   = 1'b1;
                        slot_nxt  = 2'd0;
                        state_nxt = HUNT;
                    end else begin
                        slot_nxt   = slot + 2'd1;
                        frame_done = (slot == 2'd3);
                        stage_wr   = (slot != 2'd3);
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    slot_nxt  = 2'd0;
                end
            endcase
        end
    end

    // Staging registers for slots 0..2 of the frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (stage_wr && wr_idx == 2'(k))
                    staging[k] <= in_data;
            end
        end
    end

    // Frame publish: out_data only ever changes with a complete frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                out_data  <= {in_data, staging};
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Sync-error pulse and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            sync_err <= err_det;
            if (err_det && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: framing, error handling, reset, counter limits.
module tb_tdm_demux4;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_sof;
    logic [4*WIDTH-1:0] out_data;
    logic               frame_valid;
    logic               locked;
    logic               sync_err;
    logic [15:0]        frame_cnt;
    logic [7:0]         err_cnt;

    int checks   = 0;
    int failures = 0;

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .out_data    (out_data),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one valid word, let one edge take it, then sample 1ns later.
    task automatic word(input logic sof, input logic [7:0] d);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges (called at posedge+1).
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // frame_valid and sync_err must never coincide.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("fv_se_excl", {62'd0, frame_valid, sync_err} == 64'd3, 64'd0);
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
        #3;
        chk("rst_out_data", out_data, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        #3 rst_n = 1'b1;

        // Basic back-to-back frame.
        word(1'b1, 8'h11);
        chk("t1_locked_early", locked, 1);
        word(1'b0, 8'h22);
        word(1'b0, 8'h33);
        chk("t1_fv_pre", frame_valid, 0);
        word(1'b0, 8'h44);
        chk("t1_out", out_data, 32'h44332211);
        chk("t1_fv", frame_valid, 1);
        chk("t1_fcnt", frame_cnt, 1);
        chk("t1_locked", locked, 1);
        chk("t1_se", sync_err, 0);
        idle();
        chk("t1_fv_drop", frame_valid, 0);
        chk("t1_out_hold", out_data, 32'h44332211);

        // Hunt discards non-sof words silently.
        do_reset();
        word(1'b0, 8'hAA);
        chk("t2_se_aa", sync_err, 0);
        word(1'b0, 8'hBB);
        chk("t2_se_bb", sync_err, 0);
        chk("t2_unlocked", locked, 0);
        word(1'b1, 8'h01);
        word(1'b0, 8'h02);
        word(1'b0, 8'h03);
        word(1'b0, 8'h04);
        chk("t2_out", out_data, 32'h04030201);
        chk("t2_fcnt", frame_cnt, 1);
        chk("t2_errcnt", err_cnt, 0);

        // Early sof: partial frame dropped, new frame taken.
        word(1'b1, 8'h11);
        word(1'b0, 8'h22);
        chk("t3_se_pre", sync_err, 0);
        word(1'b1, 8'h55);
        chk("t3_se", sync_err, 1);
        chk("t3_errcnt", err_cnt, 1);
        chk("t3_locked", locked, 1);
        chk("t3_out_hold", out_data, 32'h04030201);
        word(1'b0, 8'h66);
        chk("t3_se_drop", sync_err, 0);
        word(1'b0, 8'h77);
        word(1'b0, 8'h88);
        chk("t3_out", out_data, 32'h88776655);
        chk("t3_fv", frame_valid, 1);
        chk("t3_fcnt", frame_cnt, 2);
        chk("t3_errcnt_hold", err_cnt, 1);

        // Missing sof after a complete frame drops lock.
        word(1'b1, 8'hA1);
        word(1'b0, 8'hB2);
        word(1'b0, 8'hC3);
        word(1'b0, 8'hD4);
        chk("t4_out", out_data, 32'hD4C3B2A1);
        chk("t4_fcnt", frame_cnt, 3);
        word(1'b0, 8'h99);
        chk("t4_se", sync_err, 1);
        chk("t4_unlocked", locked, 0);
        chk("t4_fv", frame_valid, 0);
        chk("t4_out_hold", out_data, 32'hD4C3B2A1);
        chk("t4_errcnt", err_cnt, 2);

        // Asynchronous reset mid-frame.
        word(1'b1, 8'h10);
        word(1'b0, 8'h20);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_out", out_data, 0);
        chk("t5_rst_fcnt", frame_cnt, 0);
        chk("t5_rst_errcnt", err_cnt, 0);
        chk("t5_rst_locked", locked, 0);
        chk("t5_rst_fv", frame_valid, 0);
        chk("t5_rst_se", sync_err, 0);
        #1 rst_n = 1'b1;
        word(1'b0, 8'h30);
        chk("t5_hunt_se", sync_err, 0);
        word(1'b1, 8'h31);
        word(1'b0, 8'h32);
        idle();
        chk("t5_idle_locked", locked, 1);
        chk("t5_idle_out", out_data, 0);
        word(1'b0, 8'h33);
        word(1'b0, 8'h34);
        chk("t5_out", out_data, 32'h34333231);
        chk("t5_fcnt", frame_cnt, 1);
        chk("t5_fv", frame_valid, 1);

        // Error counter saturates at 255.
        word(1'b1, 8'h00);
        for (int i = 0; i < 300; i++) begin
            word(1'b1, 8'(i));
            if (i == 253) chk("t6_errcnt_254", err_cnt, 254);
            if (i == 254) chk("t6_errcnt_255", err_cnt, 255);
        end
        chk("t6_errcnt_sat", err_cnt, 255);
        chk("t6_se_sat", sync_err, 1);
        chk("t6_locked", locked, 1);

        // Frame counter wraps after 65536 frames.
        do_reset();
        for (int f = 0; f < 65536; f++) begin
            word(1'b1, 8'(f));
            word(1'b0, 8'(f >> 8));
            word(1'b0, 8'h5A);
            word(1'b0, 8'hA5);
            if (f == 0) chk("t7_fcnt_1", frame_cnt, 1);
            if (f == 65534) chk("t7_fcnt_max", frame_cnt, 16'hFFFF);
        end
        chk("t7_fcnt_wrap", frame_cnt, 0);
        chk("t7_fv", frame_valid, 1);
        chk("t7_out", out_data, 32'hA55AFFFF);
        chk("t7_errcnt", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
